// File: rtl/seq_divider_if.sv
// seq_divider_if: start/finish handshake and operand/result bus for the sequential divider
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             finish;
  modport master (output start, a, b, input quotient, remainder, div_by_zero, finish);
  modport slave (input start, a, b, output quotient, remainder, div_by_zero, finish);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, start/finish handshake
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, CALC = 2'b10, DONE = 2'b11} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] q_sr, q_n, dvs, dvs_n, quo, quo_n, rem, rem_n;
  // The partial remainder stays below the divisor, so its extra top bit is always zero
  // between iterations and only the lower WIDTH bits are stored.
  logic [WIDTH-1:0] r_sr, r_n;
  logic [WIDTH:0]   shifted, trial;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dz, dz_n;
  assign shifted = {r_sr, q_sr[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs};
  always_comb begin
    state_n = state;
    q_n = q_sr;
    r_n = r_sr;
    dvs_n = dvs;
    cnt_n = cnt;
    quo_n = quo;
    rem_n = rem;
    dz_n = dz;
    case (state)
      IDLE: if (bus.start) begin
        q_n = bus.a;
        dvs_n = bus.b;
        r_n = '0;
        cnt_n = '0;
        state_n = INIT;
      end
      INIT: begin
        state_n = dvs == '0 ? DONE : CALC;
        cnt_n = '0;
        if (dvs == '0) begin
          quo_n = '1;
          rem_n = q_sr;
          dz_n = 1'b1;
        end
      end
      CALC: begin
        r_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_n = {q_sr[WIDTH-2:0], ~trial[WIDTH]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = DONE;
          quo_n = q_n;
          rem_n = r_n;
          dz_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q_sr <= '0;
      r_sr <= '0;
      dvs <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      q_sr <= q_n;
      r_sr <= r_n;
      dvs <= dvs_n;
      cnt <= cnt_n;
      quo <= quo_n;
      rem <= rem_n;
      dz <= dz_n;
    end
  end
  assign bus.quotient = quo;
  assign bus.remainder = rem;
  assign bus.div_by_zero = dz;
  assign bus.finish = state == DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH = 32)
module tb_seq_divider;
  logic clk, rst;
  int   n_cmp, n_fail;
  seq_divider_if #(.WIDTH(32)) bus();
  seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // Issues one op; lat is the edge (accept = 0) at which finish is first captured, -1 if never.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat, output int pulses,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    lat = -1;
    pulses = 0;
    q = '0;
    r = '0;
    dz = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.finish) begin
        pulses++;
        if (lat < 0) begin
          lat = e + 1;
          q = bus.quotient;
          r = bus.remainder;
          dz = bus.div_by_zero;
        end
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.finish} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h dz=%b fin=%b, need all 0", bus.quotient, bus.remainder, bus.div_by_zero, bus.finish);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_basic();
    int lat, pulses;
    logic [31:0] q, r;
    logic dz;
    do_op(32'd100, 32'd7, lat, pulses, q, r, dz);
    n_cmp++;
    if (lat !== 34) begin n_fail++; $display("FAIL basic_latency: got %0d, need 34", lat); end
    n_cmp++;
    if (pulses !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d, need 1", pulses); end
    n_cmp++;
    if ({q, r, dz} !== {32'd14, 32'd2, 1'b0}) begin n_fail++; $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b, need 14 2 0", q, r, dz); end
  endtask
  task automatic test_async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.finish} !== 66'd0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h r=%h dz=%b fin=%b, need all 0", bus.quotient, bus.remainder, bus.div_by_zero, bus.finish);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_extremes();
    int lat, pulses;
    logic [31:0] q, r;
    logic dz;
    do_op(32'hFFFFFFFF, 32'd1, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r, dz} !== {32'hFFFFFFFF, 32'd0, 1'b0} || lat !== 34) begin n_fail++; $display("FAIL max_div_1: got q=%h r=%h dz=%b lat=%0d, need ffffffff 0 0 34", q, r, dz, lat); end
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r, dz} !== {32'd1, 32'd0, 1'b0}) begin n_fail++; $display("FAIL max_div_max: got q=%h r=%h dz=%b, need 1 0 0", q, r, dz); end
    do_op(32'd5, 32'd10, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r} !== {32'd0, 32'd5}) begin n_fail++; $display("FAIL small_div_large: got q=%0d r=%0d, need 0 5", q, r); end
    do_op(32'd0, 32'd3, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL zero_dividend: got q=%0d r=%0d, need 0 0", q, r); end
  endtask
  task automatic test_div_by_zero();
    int lat, pulses;
    logic [31:0] q, r;
    logic dz;
    do_op(32'd1234, 32'd0, lat, pulses, q, r, dz);
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL dbz_latency: got %0d, need 2", lat); end
    n_cmp++;
    if (pulses !== 1) begin n_fail++; $display("FAIL dbz_pulses: got %0d, need 1", pulses); end
    n_cmp++;
    if ({q, r, dz} !== {32'hFFFFFFFF, 32'd1234, 1'b1}) begin n_fail++; $display("FAIL dbz_result: got q=%h r=%0d dz=%b, need ffffffff 1234 1", q, r, dz); end
    do_op(32'd9, 32'd3, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r, dz} !== {32'd3, 32'd0, 1'b0}) begin n_fail++; $display("FAIL dbz_clear: got q=%0d r=%0d dz=%b, need 3 0 0", q, r, dz); end
  endtask
  task automatic test_back_to_back();
    int f[$];
    logic [31:0] q[$], r[$];
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd20;
    bus.b = 32'd3;
    @(posedge clk);
    for (int e = 1; e <= 110; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) begin bus.a = 32'd50; bus.b = 32'd7; end
      if (e == 40) begin bus.start = 1'b0; bus.a = 32'd99; bus.b = 32'd2; end
      if (bus.finish) begin f.push_back(e); q.push_back(bus.quotient); r.push_back(bus.remainder); end
    end
    n_cmp++;
    if (f.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d finish pulses, need 2", f.size()); end
    else begin
      n_cmp++;
      if (f[0] + 1 !== 34) begin n_fail++; $display("FAIL b2b_first_edge: got %0d, need 34", f[0] + 1); end
      n_cmp++;
      if (f[1] - f[0] !== 35) begin n_fail++; $display("FAIL b2b_spacing: got %0d, need 35", f[1] - f[0]); end
      n_cmp++;
      if ({q[0], r[0]} !== {32'd6, 32'd2}) begin n_fail++; $display("FAIL b2b_op1: got q=%0d r=%0d, need 6 2", q[0], r[0]); end
      n_cmp++;
      if ({q[1], r[1]} !== {32'd7, 32'd1}) begin n_fail++; $display("FAIL b2b_op2: got q=%0d r=%0d, need 7 1", q[1], r[1]); end
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder} !== {32'd7, 32'd1}) begin n_fail++; $display("FAIL b2b_hold: got q=%0d r=%0d, need 7 1", bus.quotient, bus.remainder); end
  endtask
  task automatic test_mid_calc_reset();
    int lat, pulses;
    logic [31:0] q, r;
    logic dz;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd77;
    bus.b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.finish} !== 66'd0) begin
      n_fail++;
      $display("FAIL midcalc_reset: got q=%h r=%h dz=%b fin=%b, need all 0", bus.quotient, bus.remainder, bus.div_by_zero, bus.finish);
    end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (bus.finish) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midcalc_no_finish: got %0d pulses, need 0", pulses); end
    do_op(32'd1000, 32'd33, lat, pulses, q, r, dz);
    n_cmp++;
    if ({q, r, dz} !== {32'd30, 32'd10, 1'b0} || lat !== 34) begin n_fail++; $display("FAIL midcalc_recover: got q=%0d r=%0d dz=%b lat=%0d, need 30 10 0 34", q, r, dz, lat); end
  endtask
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_async_reset();
    test_extremes();
    test_div_by_zero();
    test_back_to_back();
    test_mid_calc_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
